pe_result_drain: RTL and testbench

Downstream stage of the processing element. When a tile's accumulation finishes, it snapshots all NUM_MACS accumulator outputs (2*DATA_WIDTH each). It then requantizes each lane to DATA_WIDTH with round-half-up and saturation, and streams the lanes out one word per cycle over a valid/ready interface to the activation/writeback path. Its `busy` output lets the tile controller hold off the next `rst_acc` until the snapshot is safe.

---
 rtl/pe_pkg.sv | 23 ++
 rtl/pe_result_drain_requant_sat.sv | 49 ++++
 rtl/pe_result_drain.sv | 129 ++++++++++++
 tb/tb_pe_result_drain.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the processing-element datapath:
// drain FSM states, accumulator width and requant saturation limits.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } drain_state_t;

  function automatic int ACC_WIDTH(input int w);
    return 2 * w;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/pe_result_drain_requant_sat.sv
// Combinational requantizer: round-half-up arithmetic right shift of a
// 2W-bit accumulator followed by saturation to a signed W-bit word.
module requant_sat
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic signed [2*DATA_WIDTH-1:0] acc,
  input  logic        [SHIFT_WIDTH-1:0]  shift,
  output logic signed [DATA_WIDTH-1:0]   data,
  output logic                           sat
);

  localparam int ACC_W = ACC_WIDTH(DATA_WIDTH);
  localparam int EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] MAX_X = EXT_W'(sat_max(DATA_WIDTH));
  localparam logic signed [EXT_W-1:0] MIN_X = EXT_W'(sat_min(DATA_WIDTH));

  // One guard bit keeps the rounding add from wrapping at the accumulator max.
  function automatic logic signed [EXT_W-1:0] round_shift(
    input logic signed [ACC_W-1:0]       a,
    input logic        [SHIFT_WIDTH-1:0] s
  );
    int                       sh;
    logic signed [EXT_W-1:0]  ext;
    logic signed [EXT_W-1:0]  rnd;
    sh  = (int'(s) >= ACC_W) ? ACC_W - 1 : int'(s);
    ext = {a[ACC_W-1], a};
    rnd = (sh > 0) ? (EXT_W'(1) << (sh - 1)) : '0;
    return (ext + rnd) >>> sh;
  endfunction

  // Returns {sat, word}.
  function automatic logic [DATA_WIDTH:0] saturate(input logic signed [EXT_W-1:0] r);
    if (r > MAX_X) begin
      return {1'b1, MAX_X[DATA_WIDTH-1:0]};
    end else if (r < MIN_X) begin
      return {1'b1, MIN_X[DATA_WIDTH-1:0]};
    end else begin
      return {1'b0, r[DATA_WIDTH-1:0]};
    end
  endfunction

  always_comb begin
    {sat, data} = saturate(round_shift(acc, shift));
  end

endmodule

// File: rtl/pe_result_drain.sv
// Snapshots a finished tile's accumulators and streams the requantized lanes
// out one word per cycle over valid/ready; busy gates the next tile_done.
module pe_result_drain
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_MACS    = 4,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 tile_done,
  input  logic [NUM_MACS*2*DATA_WIDTH-1:0]     acc_flat,
  input  logic [SHIFT_WIDTH-1:0]               shift,
  output logic                                 busy,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_MACS)-1:0]          out_idx,
  output logic                                 out_last,
  output logic                                 out_sat,
  output logic                                 drop_err
);

  localparam int ACC_W = ACC_WIDTH(DATA_WIDTH);
  localparam int IDX_W = $clog2(NUM_MACS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MACS - 1);

  drain_state_t state, state_nx;

  logic signed [ACC_W-1:0]      lane_p0 [NUM_MACS];
  logic [SHIFT_WIDTH-1:0]       shift_p0;
  logic [IDX_W-1:0]             idx_p0;

  logic signed [DATA_WIDTH-1:0] data_p1;
  logic                         sat_p1;
  logic [IDX_W-1:0]             idx_p1;
  logic                         drop_p1;

  logic signed [DATA_WIDTH-1:0] rq_data;
  logic                         rq_sat;
  logic                         hs;
  logic                         last;
  logic                         capture;
  logic                         load;

  assign out_valid = (state == DRAIN);
  assign hs        = out_valid & out_ready;
  assign last      = (idx_p1 == LAST_IDX);
  // A tile may land in the same cycle the final lane leaves.
  assign busy      = (state != IDLE) & ~((state == DRAIN) & hs & last);
  assign capture   = tile_done & ~busy;

  assign out_data  = data_p1;
  assign out_idx   = idx_p1;
  assign out_sat   = sat_p1;
  assign out_last  = last;
  assign drop_err  = drop_p1;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (capture) state_nx = FILL;
      end
      FILL: begin
        load     = 1'b1;
        state_nx = DRAIN;
      end
      DRAIN: begin
        if (hs) begin
          if (last) state_nx = capture ? FILL : IDLE;
          else      load     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: tile snapshot (data only, contents irrelevant after reset)
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NUM_MACS; i++) begin
        lane_p0[i] <= acc_flat[i*ACC_W +: ACC_W];
      end
      shift_p0 <= shift;
    end
  end

  requant_sat #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_requant (
    .acc   (lane_p0[idx_p0]),
    .shift (shift_p0),
    .data  (rq_data),
    .sat   (rq_sat)
  );

  // Stage p1: output register, lane pointer and sticky drop flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_p0  <= '0;
      idx_p1  <= '0;
      data_p1 <= '0;
      sat_p1  <= 1'b0;
      drop_p1 <= 1'b0;
    end else begin
      if (capture) begin
        idx_p0 <= '0;
      end else if (load) begin
        idx_p0 <= (idx_p0 == LAST_IDX) ? '0 : idx_p0 + IDX_W'(1);
      end
      if (load) begin
        idx_p1  <= idx_p0;
        data_p1 <= rq_data;
        sat_p1  <= rq_sat;
      end
      if (tile_done & busy) drop_p1 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain with hand-computed requant results.
module tb_pe_result_drain;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int SW = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    tile_done;
  logic [N*2*W-1:0]        acc_flat;
  logic [SW-1:0]           shift;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [W-1:0]     out_data;
  logic [$clog2(N)-1:0]    out_idx;
  logic                    out_last;
  logic                    out_sat;
  logic                    drop_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_result_drain #(
    .DATA_WIDTH  (W),
    .NUM_MACS    (N),
    .SHIFT_WIDTH (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tile_done (tile_done),
    .acc_flat  (acc_flat),
    .shift     (shift),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .drop_err  (drop_err)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic load_acc(input longint a0, input longint a1, input longint a2,
                          input longint a3, input int sh);
    acc_flat = {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    shift    = SW'(sh);
  endtask

  task automatic start_tile(input longint a0, input longint a1, input longint a2,
                            input longint a3, input int sh);
    load_acc(a0, a1, a2, a3, sh);
    tile_done = 1'b1;
    chk("cap_busy", busy, 0);
    tick;
    tile_done = 1'b0;
    chk("fill_valid", out_valid, 0);
    chk("fill_busy", busy, 1);
    tick;
  endtask

  task automatic expect_lane(input string tag, input int i, input longint d, input bit s);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_idx"}, out_idx, i);
    chk({tag, "_last"}, out_last, (i == N - 1) ? 1 : 0);
    chk({tag, "_sat"}, out_sat, s);
  endtask

  task automatic drain(input string tag, input longint d[4], input bit s[4]);
    for (int i = 0; i < N; i++) begin
      expect_lane(tag, i, d[i], s[i]);
      if (i == N - 1) chk({tag, "_busy_last"}, busy, 0);
      else            chk({tag, "_busy"}, busy, 1);
      tick;
    end
    chk({tag, "_end_valid"}, out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    tile_done = 1'b1;
    out_ready = 1'b1;
    load_acc(1, 2, 3, 4, 0);

    // reset held with tile_done asserted
    repeat (3) begin
      tick;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop_err, 0);
      chk("rst_data", out_data, 0);
    end
    rst       = 1'b1;
    tile_done = 1'b0;
    tick;
    chk("idle_valid", out_valid, 0);

    // basic drain, shift 2
    start_tile(100, -100, 7, -7, 2);
    drain("basic", '{25, -25, 2, -2}, '{0, 0, 0, 0});

    // saturation, shift 0
    start_tile(65536, -70000, 32767, -32768, 0);
    drain("sat", '{32767, -32768, 32767, -32768}, '{1, 1, 0, 0});

    // round-half-up at shift 1
    start_tile(3, -3, 1, -1, 1);
    drain("rnd", '{2, -1, 1, 0}, '{0, 0, 0, 0});

    // backpressure on lane 1
    start_tile(100, -100, 7, -7, 2);
    expect_lane("bp0", 0, 25, 0);
    tick;
    for (int k = 0; k < 5; k++) begin
      out_ready = 1'b0;
      expect_lane("bp_hold", 1, -25, 0);
      tick;
    end
    out_ready = 1'b1;
    expect_lane("bp1", 1, -25, 0);
    tick;
    expect_lane("bp2", 2, 2, 0);
    tick;
    expect_lane("bp3", 3, -2, 0);
    tick;
    chk("bp_end_valid", out_valid, 0);

    // tile_done during lane 1 is dropped
    start_tile(100, -100, 7, -7, 2);
    expect_lane("col1_0", 0, 25, 0);
    tick;
    expect_lane("col1_1", 1, -25, 0);
    chk("col1_pre_drop", drop_err, 0);
    load_acc(9, 9, 9, 9, 0);
    tile_done = 1'b1;
    chk("col1_busy", busy, 1);
    tick;
    tile_done = 1'b0;
    chk("col1_drop", drop_err, 1);
    expect_lane("col1_2", 2, 2, 0);
    tick;
    expect_lane("col1_3", 3, -2, 0);
    tick;
    chk("col1_end_valid", out_valid, 0);
    tick;
    chk("col1_no_tile", out_valid, 0);

    // tile_done on the lane-3 handshake is captured
    start_tile(100, -100, 7, -7, 2);
    expect_lane("col2_0", 0, 25, 0);
    tick;
    expect_lane("col2_1", 1, -25, 0);
    tick;
    expect_lane("col2_2", 2, 2, 0);
    tick;
    expect_lane("col2_3", 3, -2, 0);
    load_acc(400, -400, 40, -40, 3);
    tile_done = 1'b1;
    chk("col2_busy", busy, 0);
    tick;
    tile_done = 1'b0;
    chk("col2_fill_valid", out_valid, 0);
    chk("col2_fill_busy", busy, 1);
    tick;
    drain("col2_new", '{50, -50, 5, -5}, '{0, 0, 0, 0});
    chk("col2_drop_kept", drop_err, 1);

    // reset after lane 1 handshake aborts the stream
    start_tile(100, -100, 7, -7, 2);
    expect_lane("mr0", 0, 25, 0);
    tick;
    expect_lane("mr1", 1, -25, 0);
    tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    chk("mr_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_drop", drop_err, 0);
    chk("mr_data", out_data, 0);
    repeat (4) begin
      tick;
      chk("mr_quiet", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
